// File: rtl/psram_tg_pkg.sv
// Shared state encoding, mode/pattern codes and LFSR definition for the
// PSRAM traffic generator and its pattern source.
package psram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_REQ,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } tg_state_e;

  typedef enum logic [1:0] {
    MODE_WRITE     = 2'd0,
    MODE_READ      = 2'd1,
    MODE_WR_VERIFY = 2'd2,
    MODE_RSVD      = 2'd3
  } tg_mode_e;

  typedef enum logic [1:0] {
    PAT_BYTE_INC  = 2'd0,
    PAT_LFSR      = 2'd1,
    PAT_ADDR_BEAT = 2'd2,
    PAT_RSVD      = 2'd3
  } tg_pattern_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0406_0103;

  // Right-shifting Galois form: the feedback mask is applied when the bit
  // shifted out is one.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/psram_pattern_gen.sv
// Data pattern source shared by the write and read-check phases; the current
// word is held in a register so it can drive the controller directly.
module psram_pattern_gen
  import psram_tg_pkg::*;
#(
  parameter int          DW     = 32,
  parameter int          ADDR_W = 32,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_rebase,
  input  logic              i_advance,
  input  tg_pattern_e       i_sel,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DW-1:0]     o_word
);

  localparam logic [31:0] LFSR_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [DW-1:0] r_word;
  logic [DW-1:0] w_next;
  logic [DW-1:0] w_byte_inc;
  logic [DW-1:0] w_lfsr_next;
  logic [DW-1:0] w_addr_word;

  always_comb begin
    w_byte_inc = r_word;
    for (int b = 0; b < DW / 8; b++) begin
      w_byte_inc[b*8 +: 8] = r_word[b*8 +: 8] + 8'd1;
    end
  end

  assign w_lfsr_next = DW'(lfsr32_step(32'(r_word)));
  assign w_addr_word = DW'(i_addr);

  // Address+beat restarts from the burst address at every burst; the other
  // patterns keep running across bursts and only restart on a full load.
  always_comb begin
    w_next = r_word;
    if (i_load) begin
      case (i_sel)
        PAT_LFSR:      w_next = DW'(LFSR_SEED);
        PAT_ADDR_BEAT: w_next = w_addr_word;
        default:       w_next = DW'(SEED);
      endcase
    end else if (i_rebase && (i_sel == PAT_ADDR_BEAT)) begin
      w_next = w_addr_word;
    end else if (i_advance) begin
      case (i_sel)
        PAT_LFSR:      w_next = w_lfsr_next;
        PAT_ADDR_BEAT: w_next = r_word + DW'(1);
        default:       w_next = w_byte_inc;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= DW'(SEED);
    end else begin
      r_word <= w_next;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/psram_traffic_gen.sv
// Burst write / read / write-then-verify engine for the user side of
// psram_controller, with error count, first failing location and timeout.
module psram_traffic_gen
  import psram_tg_pkg::*;
#(
  parameter int          BIT_WIDTH = 16,
  parameter int          ADDR_W    = 32,
  parameter int          BEATS     = 8,
  parameter int          ADDR_STEP = 16,
  parameter int          ADDR_SPAN = 2**20,
  parameter logic [31:0] SEED      = DEFAULT_SEED,
  parameter int          TIMEOUT   = 1024,
  parameter int          CNT_W     = 16,
  localparam int         BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   ram_clk,
  input  logic                   ram_rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [1:0]             pattern,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       num_bursts,
  input  logic                   init_cable_complete,
  input  logic                   ctrl_idle,
  input  logic                   ram_wr_valid,
  input  logic                   ram_rd_valid,
  input  logic [2*BIT_WIDTH-1:0] ram_data_out,
  output logic                   ram_en,
  output logic                   rw_ctrl,
  output logic [ADDR_W-1:0]      addr_in,
  output logic [2*BIT_WIDTH-1:0] ram_data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [BEAT_W-1:0]      first_err_beat
);

  localparam int                DW        = 2 * BIT_WIDTH;
  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] SPAN_MASK = ADDR_W'(ADDR_SPAN - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  tg_state_e         r_state;
  tg_mode_e          r_mode;
  tg_pattern_e       r_pattern;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_burst;
  logic [BEAT_W-1:0] r_beat;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_read_phase;
  logic              r_ram_en;
  logic              r_rw;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_first_addr;
  logic [BEAT_W-1:0] r_first_beat;

  tg_mode_e          w_mode_in;
  tg_pattern_e       w_pattern_in;
  tg_pattern_e       w_pat_sel;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_pat_addr;
  logic [DW-1:0]     w_pat_word;
  logic              w_ready;
  logic              w_beat_hit;
  logic              w_mismatch;
  logic              w_last_burst;
  logic              w_switch_phase;
  logic              w_tmo_hit;
  logic              w_pat_load;
  logic              w_pat_rebase;

  assign w_mode_in    = (mode == 2'd3) ? MODE_WRITE : tg_mode_e'(mode);
  assign w_pattern_in = (pattern == 2'd3) ? PAT_BYTE_INC : tg_pattern_e'(pattern);

  assign w_ready        = init_cable_complete & ctrl_idle;
  assign w_beat_hit     = (r_state == ST_XFER) &&
                          (r_read_phase ? ram_rd_valid : ram_wr_valid);
  assign w_mismatch     = w_beat_hit && r_read_phase && (ram_data_out != w_pat_word);
  assign w_last_burst   = ((r_burst + CNT_W'(1)) == r_num);
  assign w_switch_phase = w_last_burst && (r_mode == MODE_WR_VERIFY) && !r_read_phase;
  assign w_tmo_hit      = (r_tmo == TMO_LIMIT);

  // Offset wraps inside the ADDR_SPAN window; bits above the span stay at base.
  assign w_next_addr = (r_addr & ~SPAN_MASK) | ((r_addr + STEP) & SPAN_MASK);

  assign w_pat_sel    = (r_state == ST_IDLE) ? w_pattern_in : r_pattern;
  assign w_pat_load   = ((r_state == ST_IDLE) && start) ||
                        ((r_state == ST_NEXT) && w_switch_phase);
  assign w_pat_rebase = (r_state == ST_NEXT) && !w_last_burst;
  assign w_pat_addr   = (r_state == ST_IDLE) ? base_addr :
                        w_switch_phase       ? r_base    : w_next_addr;

  psram_pattern_gen #(
    .DW     (DW),
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_pattern (
    .i_clk     (ram_clk),
    .i_rst     (ram_rst),
    .i_load    (w_pat_load),
    .i_rebase  (w_pat_rebase),
    .i_advance (w_beat_hit),
    .i_sel     (w_pat_sel),
    .i_addr    (w_pat_addr),
    .o_word    (w_pat_word)
  );

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_WRITE;
      r_pattern    <= PAT_BYTE_INC;
      r_base       <= '0;
      r_addr       <= '0;
      r_num        <= '0;
      r_burst      <= '0;
      r_beat       <= '0;
      r_tmo        <= '0;
      r_read_phase <= 1'b0;
      r_ram_en     <= 1'b0;
      r_rw         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= '0;
      r_first_addr <= '0;
      r_first_beat <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode       <= w_mode_in;
            r_pattern    <= w_pattern_in;
            r_base       <= base_addr;
            r_addr       <= base_addr;
            r_num        <= num_bursts;
            r_burst      <= '0;
            r_tmo        <= '0;
            r_read_phase <= (w_mode_in == MODE_READ);
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= '0;
            r_first_addr <= '0;
            r_first_beat <= '0;
            r_state      <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (r_num == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else if (w_ready) begin
            r_state  <= ST_REQ;
            r_ram_en <= 1'b1;
            r_rw     <= !r_read_phase;
            r_tmo    <= '0;
          end else if (w_tmo_hit) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_REQ: begin
          r_state <= ST_XFER;
          r_beat  <= '0;
          r_tmo   <= '0;
        end
        ST_XFER: begin
          if (w_beat_hit) begin
            r_tmo  <= '0;
            r_beat <= r_beat + BEAT_W'(1);
            if (w_mismatch) begin
              if (r_err != {CNT_W{1'b1}}) begin
                r_err <= r_err + CNT_W'(1);
              end
              if (r_err == '0) begin
                r_first_addr <= r_addr;
                r_first_beat <= r_beat;
              end
            end
            if (r_beat == LAST_BEAT) begin
              r_state <= ST_NEXT;
            end
          end else if (w_tmo_hit) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_NEXT: begin
          r_tmo <= '0;
          if (!w_last_burst) begin
            r_burst <= r_burst + CNT_W'(1);
            r_addr  <= w_next_addr;
            r_state <= ST_WAIT_RDY;
          end else if (w_switch_phase) begin
            r_burst      <= '0;
            r_addr       <= r_base;
            r_read_phase <= 1'b1;
            r_state      <= ST_WAIT_RDY;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_err == '0);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_en         = r_ram_en;
  assign rw_ctrl        = r_rw;
  assign addr_in        = r_addr;
  assign ram_data_in    = w_pat_word;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err;
  assign first_err_addr = r_first_addr;
  assign first_err_beat = r_first_beat;

endmodule

// File: tb/tb_psram_traffic_gen.sv
// Scoreboard bench for psram_traffic_gen: an ideal controller model answers
// requests while expected addresses and write words are popped from queues.
module tb_psram_traffic_gen;

  localparam int          BEATS = 8;
  localparam int          STEP  = 16;
  localparam int          SPAN  = 1 << 20;
  localparam int          TMO   = 1024;
  localparam logic [31:0] SEED  = 32'h0406_0103;

  logic        ram_clk;
  logic        ram_rst;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  pattern;
  logic [31:0] base_addr;
  logic [15:0] num_bursts;
  logic        init_cable_complete;
  logic        ctrl_idle;
  logic        ram_wr_valid;
  logic        ram_rd_valid;
  logic [31:0] ram_data_out;
  logic        ram_en;
  logic        rw_ctrl;
  logic [31:0] addr_in;
  logic [31:0] ram_data_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic [2:0]  first_err_beat;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expWordQ[$];
  logic [31:0] expAddrQ[$];
  logic        expRwQ[$];
  logic [31:0] memModel[logic [39:0]];
  int          enCount     = 0;
  int          readBurstIdx = 0;
  int          injectBurst = -1;
  int          injectBeat  = 0;
  bit          abortCtrl   = 0;

  psram_traffic_gen dut (
    .ram_clk             (ram_clk),
    .ram_rst             (ram_rst),
    .start               (start),
    .mode                (mode),
    .pattern             (pattern),
    .base_addr           (base_addr),
    .num_bursts          (num_bursts),
    .init_cable_complete (init_cable_complete),
    .ctrl_idle           (ctrl_idle),
    .ram_wr_valid        (ram_wr_valid),
    .ram_rd_valid        (ram_rd_valid),
    .ram_data_out        (ram_data_out),
    .ram_en              (ram_en),
    .rw_ctrl             (rw_ctrl),
    .addr_in             (addr_in),
    .ram_data_in         (ram_data_in),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .err_cnt             (err_cnt),
    .first_err_addr      (first_err_addr),
    .first_err_beat      (first_err_beat)
  );

  initial ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] patAdvance(input logic [1:0] p, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (p == 2'd1) begin
      r = (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0);
    end else begin
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = w[i*8 +: 8] + 8'd1;
    end
    return r;
  endfunction

  function automatic logic [31:0] wrapAddr(input logic [31:0] base, input int k);
    logic [31:0] mask;
    mask = 32'(SPAN - 1);
    return (base & ~mask) | ((base + 32'(k * STEP)) & mask);
  endfunction

  // Ideal controller: answers each ram_en with BEATS strobes starting the
  // following cycle, storing writes and returning them on reads.
  initial begin : ctrlModel
    logic [31:0] a;
    logic        isWr;
    logic [39:0] key;
    ram_wr_valid = 1'b0;
    ram_rd_valid = 1'b0;
    ram_data_out = '0;
    forever begin
      @(negedge ram_clk);
      if (ram_en === 1'b1) begin
        enCount++;
        a    = addr_in;
        isWr = rw_ctrl;
        checkOutput("reqExpected", 64'(expAddrQ.size() > 0), 64'd1);
        if (expAddrQ.size() > 0) begin
          checkOutput("reqAddr", a, expAddrQ.pop_front());
          checkOutput("reqRw", isWr, expRwQ.pop_front());
        end
        @(negedge ram_clk);
        for (int b = 0; b < BEATS; b++) begin
          if (abortCtrl) break;
          key = {a, 8'(b)};
          if (isWr) begin
            ram_wr_valid = 1'b1;
            memModel[key] = ram_data_in;
            checkOutput("wdataExpected", 64'(expWordQ.size() > 0), 64'd1);
            if (expWordQ.size() > 0) checkOutput("wdata", ram_data_in, expWordQ.pop_front());
          end else begin
            ram_rd_valid = 1'b1;
            ram_data_out = memModel.exists(key) ? memModel[key] : 32'h0;
            if (readBurstIdx == injectBurst && b == injectBeat) ram_data_out ^= 32'h0000_0100;
          end
          @(negedge ram_clk);
        end
        ram_wr_valid = 1'b0;
        ram_rd_valid = 1'b0;
        if (!isWr) readBurstIdx++;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] p,
                               input logic [31:0] base, input int n);
    logic [31:0] w;
    logic [31:0] a;
    expWordQ.delete();
    expAddrQ.delete();
    expRwQ.delete();
    enCount      = 0;
    readBurstIdx = 0;
    w = SEED;
    if (m != 2'd1) begin
      for (int k = 0; k < n; k++) begin
        a = wrapAddr(base, k);
        expAddrQ.push_back(a);
        expRwQ.push_back(1'b1);
        for (int b = 0; b < BEATS; b++) begin
          if (p == 2'd2) begin
            expWordQ.push_back(a + 32'(b));
          end else begin
            expWordQ.push_back(w);
            w = patAdvance(p, w);
          end
        end
      end
    end
    if (m == 2'd1 || m == 2'd2) begin
      for (int k = 0; k < n; k++) begin
        expAddrQ.push_back(wrapAddr(base, k));
        expRwQ.push_back(1'b0);
      end
    end
    @(negedge ram_clk);
    mode       = m;
    pattern    = p;
    base_addr  = base;
    num_bursts = 16'(n);
    start      = 1'b1;
    @(negedge ram_clk);
    start = 1'b0;
    checkOutput("busyRise", busy, 1'b1);
  endtask

  task automatic waitDone(input int maxCycles, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < maxCycles) begin
      @(negedge ram_clk);
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput("doneSeen", seen, 1'b1);
  endtask

  task automatic checkEnd(input bit expPass, input int expErr, input bit expTmo, input int expEn);
    checkOutput("pass", pass, expPass);
    checkOutput("errCnt", err_cnt, 64'(expErr));
    checkOutput("timeout", timeout, expTmo);
    checkOutput("busyAtDone", busy, 1'b0);
    checkOutput("ramEnCount", 64'(enCount), 64'(expEn));
    @(negedge ram_clk);
    checkOutput("donePulse", done, 1'b0);
    checkOutput("passHeld", pass, expPass);
  endtask

  task automatic checkResetValues();
    checkOutput("rstRamEn", ram_en, 1'b0);
    checkOutput("rstRw", rw_ctrl, 1'b0);
    checkOutput("rstAddr", addr_in, 32'h0);
    checkOutput("rstData", ram_data_in, SEED);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstPass", pass, 1'b0);
    checkOutput("rstTimeout", timeout, 1'b0);
    checkOutput("rstErr", err_cnt, 16'h0);
    checkOutput("rstFirstAddr", first_err_addr, 32'h0);
    checkOutput("rstFirstBeat", first_err_beat, 3'h0);
  endtask

  initial begin : mainSeq
    int  cyc;
    bit  seen;
    int  guard;
    ram_rst             = 1'b1;
    start               = 1'b0;
    mode                = 2'd0;
    pattern             = 2'd0;
    base_addr           = '0;
    num_bursts          = '0;
    init_cable_complete = 1'b1;
    ctrl_idle           = 1'b1;
    repeat (3) @(negedge ram_clk);
    checkResetValues();
    ram_rst = 1'b0;
    @(negedge ram_clk);

    $display("[TB] write only, byte-increment, 2 bursts at 4");
    applyStimulus(2'd0, 2'd0, 32'h4, 2);
    waitDone(500, cyc, seen);
    checkEnd(1'b1, 0, 1'b0, 2);
    checkOutput("wordsLeft", 64'(expWordQ.size()), 64'd0);

    $display("[TB] write then verify, LFSR, 4 bursts");
    applyStimulus(2'd2, 2'd1, 32'h100, 4);
    waitDone(1000, cyc, seen);
    checkEnd(1'b1, 0, 1'b0, 8);
    checkOutput("addrLeft", 64'(expAddrQ.size()), 64'd0);

    $display("[TB] write then verify with one corrupted read beat");
    injectBurst = 1;
    injectBeat  = 3;
    applyStimulus(2'd2, 2'd0, 32'h40, 3);
    waitDone(1000, cyc, seen);
    checkOutput("firstErrAddr", first_err_addr, 32'h50);
    checkOutput("firstErrBeat", first_err_beat, 3'd3);
    checkEnd(1'b0, 1, 1'b0, 6);
    injectBurst = -1;

    $display("[TB] zero bursts");
    applyStimulus(2'd2, 2'd0, 32'h80, 0);
    waitDone(20, cyc, seen);
    checkOutput("zeroBurstLatency", 64'(cyc + 1), 64'd2);
    checkEnd(1'b1, 0, 1'b0, 0);

    $display("[TB] controller never idle");
    ctrl_idle = 1'b0;
    applyStimulus(2'd0, 2'd0, 32'h0, 1);
    waitDone(TMO + 50, cyc, seen);
    checkOutput("timeoutLatency", 64'(cyc), 64'(TMO + 1));
    checkEnd(1'b0, 0, 1'b1, 0);
    ctrl_idle = 1'b1;

    $display("[TB] address wrap at span, address+beat pattern");
    applyStimulus(2'd0, 2'd2, 32'(SPAN - 16), 3);
    waitDone(1000, cyc, seen);
    checkEnd(1'b1, 0, 1'b0, 3);
    checkOutput("wrapWordsLeft", 64'(expWordQ.size()), 64'd0);

    $display("[TB] reset in the middle of a write burst");
    applyStimulus(2'd0, 2'd0, 32'h200, 4);
    guard = 0;
    while (ram_wr_valid !== 1'b1 && guard < 200) begin
      @(negedge ram_clk);
      guard++;
    end
    checkOutput("xferReached", ram_wr_valid, 1'b1);
    repeat (2) @(negedge ram_clk);
    abortCtrl = 1'b1;
    ram_rst   = 1'b1;
    @(negedge ram_clk);
    checkResetValues();
    ram_rst = 1'b0;
    repeat (3) @(negedge ram_clk);
    abortCtrl = 1'b0;

    applyStimulus(2'd2, 2'd1, 32'h300, 2);
    waitDone(1000, cyc, seen);
    checkEnd(1'b1, 0, 1'b0, 4);

    repeat (3) @(negedge ram_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
